// File: rtl/rx_loader_defs.sv
// Shared definitions for the receive-side program loader: state encodings and parameter defaults.
package rx_loader_defs;

   typedef enum logic [1:0] {
      LOAD  = 2'b00,
      CHECK = 2'b01,
      DONE  = 2'b10,
      ERROR = 2'b11
   } state_t;

   localparam int unsigned ADDR_W_DEFAULT    = 10;
   localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

endpackage

// File: rtl/rx_loader_sum.sv
// Running modulo-2^32 sum of every word the loader stores; built only with RX_LOADER_CHECKSUM_EN.
module rx_loader_sum (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_clear,
   input  logic        i_add,
   input  logic [31:0] i_word,
   output logic [31:0] o_sum
);

   logic [31:0] r_sum;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sum <= '0;
      end else if (i_clear) begin
         r_sum <= '0;
      end else if (i_add) begin
         r_sum <= r_sum + i_word;
      end
   end

   assign o_sum = r_sum;

endmodule

// File: rtl/rx_program_loader.sv
// Streams UART-assembled words into instruction memory from address 0 until HALT, then releases the pipeline.
// Define RX_LOADER_CHECKSUM_EN to require a trailing checksum word before the image is accepted.
module rx_program_loader
   import rx_loader_defs::*;
#(
   parameter int unsigned ADDR_W    = ADDR_W_DEFAULT,
   parameter logic [31:0] HALT_WORD = HALT_WORD_DEFAULT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              go,
   input  logic [31:0]       din,
   input  logic              restart,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_data,
   output logic [ADDR_W:0]   word_count,
   output logic              load_done,
   output logic              pipe_enable,
   output logic              error
);

   localparam logic [ADDR_W:0] C_MEM_WORDS = {1'b1, {ADDR_W{1'b0}}};

   state_t              r_state;
   state_t              w_next_state;
   logic [ADDR_W-1:0]   r_addr;
   logic [ADDR_W:0]     r_count;
   logic                r_imem_we;
   logic [ADDR_W-1:0]   r_imem_addr;
   logic [31:0]         r_imem_data;
   logic                r_load_done;
   logic                r_pipe_enable;
   logic                r_error;
   logic                w_full;
   logic                w_write;
   logic                w_is_halt;

   assign w_full    = (r_count == C_MEM_WORDS);
   assign w_is_halt = (din == HALT_WORD);
   // restart outranks go, so a colliding word is dropped rather than written.
   assign w_write   = (r_state == LOAD) && go && !restart && !w_full;

`ifdef RX_LOADER_CHECKSUM_EN
   logic [31:0] w_sum;

   rx_loader_sum u_sum (
      .clk     (clk),
      .reset   (reset),
      .i_clear (restart),
      .i_add   (w_write),
      .i_word  (din),
      .o_sum   (w_sum)
   );
`endif

   // NOTE: next state gets its default first so no path through the case can infer a latch.
   always_comb begin
      w_next_state = r_state;
      if (restart) begin
         w_next_state = LOAD;
      end else begin
         case (r_state)
            LOAD: begin
               if (go) begin
                  if (w_full) begin
                     w_next_state = ERROR;
                  end else if (w_is_halt) begin
`ifdef RX_LOADER_CHECKSUM_EN
                     w_next_state = CHECK;
`else
                     w_next_state = DONE;
`endif
                  end
               end
            end
            CHECK: begin
`ifdef RX_LOADER_CHECKSUM_EN
               if (go) begin
                  w_next_state = (din == w_sum) ? DONE : ERROR;
               end
`else
               w_next_state = LOAD;
`endif
            end
            DONE:    w_next_state = DONE;
            ERROR:   w_next_state = ERROR;
            default: w_next_state = LOAD;
         endcase
      end
   end

   // NOTE: all state here updates with non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state       <= LOAD;
         r_addr        <= '0;
         r_count       <= '0;
         r_imem_we     <= 1'b0;
         r_imem_addr   <= '0;
         r_imem_data   <= '0;
         r_load_done   <= 1'b0;
         r_pipe_enable <= 1'b0;
         r_error       <= 1'b0;
      end else begin
         r_state   <= w_next_state;
         r_imem_we <= w_write;
         if (w_write) begin
            r_imem_addr <= r_addr;
            r_imem_data <= din;
         end
         if (restart) begin
            r_addr  <= '0;
            r_count <= '0;
         end else if (w_write) begin
            r_addr  <= r_addr + ADDR_W'(1);
            r_count <= r_count + (ADDR_W + 1)'(1);
         end
         // Status follows the settled state one edge later and drops at once on restart.
         r_load_done   <= (r_state == DONE) && (w_next_state == DONE);
         r_pipe_enable <= (r_state == DONE) && (w_next_state == DONE);
         r_error       <= (r_state == ERROR) && (w_next_state == ERROR);
      end
   end

   assign imem_we     = r_imem_we;
   assign imem_addr   = r_imem_addr;
   assign imem_data   = r_imem_data;
   assign word_count  = r_count;
   assign load_done   = r_load_done;
   assign pipe_enable = r_pipe_enable;
   assign error       = r_error;

endmodule

// File: tb/tb_rx_program_loader.sv
// Self-checking bench for rx_program_loader: table-driven cycles plus a write scoreboard, two instances.
module tb_rx_program_loader;

   localparam logic [31:0] HALT = 32'hFFFF_FFFF;

   typedef struct {
      logic        go;
      logic        rst;
      logic [31:0] din;
      logic        exp_wr;
      logic [9:0]  exp_addr;
      logic [10:0] exp_cnt;
      logic        exp_done;
   } vec_t;

   typedef struct {
      logic [9:0]  addr;
      logic [31:0] data;
   } wr_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;

   logic        d_go = 1'b0, d_restart = 1'b0;
   logic [31:0] d_din = '0;
   logic        d_we, d_done, d_pe, d_err;
   logic [9:0]  d_addr;
   logic [31:0] d_data;
   logic [10:0] d_cnt;

   logic        o_go = 1'b0, o_restart = 1'b0;
   logic [31:0] o_din = '0;
   logic        o_we, o_done, o_pe, o_err;
   logic [1:0]  o_addr;
   logic [31:0] o_data;
   logic [2:0]  o_cnt;

   int n_checks = 0;
   int n_errors = 0;
   wr_t  d_q[$];
   wr_t  o_q[$];
   vec_t vecs[$];

   always #5 clk = ~clk;

   rx_program_loader u_dut (
      .clk (clk), .reset (reset), .go (d_go), .din (d_din), .restart (d_restart),
      .imem_we (d_we), .imem_addr (d_addr), .imem_data (d_data), .word_count (d_cnt),
      .load_done (d_done), .pipe_enable (d_pe), .error (d_err)
   );

   rx_program_loader #(.ADDR_W(2)) u_ovf (
      .clk (clk), .reset (reset), .go (o_go), .din (o_din), .restart (o_restart),
      .imem_we (o_we), .imem_addr (o_addr), .imem_data (o_data), .word_count (o_cnt),
      .load_done (o_done), .pipe_enable (o_pe), .error (o_err)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic void add(input logic g, input logic r, input logic [31:0] d,
                               input logic w, input logic [9:0] a, input logic [10:0] c,
                               input logic dn);
      vec_t v;
      v.go = g; v.rst = r; v.din = d; v.exp_wr = w; v.exp_addr = a; v.exp_cnt = c; v.exp_done = dn;
      vecs.push_back(v);
   endfunction

   function automatic void push_d(input logic [9:0] a, input logic [31:0] d);
      wr_t e;
      e.addr = a; e.data = d;
      d_q.push_back(e);
   endfunction

   function automatic void push_o(input logic [9:0] a, input logic [31:0] d);
      wr_t e;
      e.addr = a; e.data = d;
      o_q.push_back(e);
   endfunction

   task automatic cyc(input logic g, input logic [31:0] d, input logic r);
      d_go = g; d_din = d; d_restart = r;
      @(posedge clk); #1;
      d_go = 1'b0; d_restart = 1'b0;
   endtask

   task automatic ocyc(input logic g, input logic [31:0] d, input logic r);
      o_go = g; o_din = d; o_restart = r;
      @(posedge clk); #1;
      o_go = 1'b0; o_restart = 1'b0;
   endtask

   // Write monitors: every imem_we pulse must match the oldest expected write.
   always @(negedge clk) begin
      if (d_we) begin
         if (d_q.size() == 0) begin
            check("d_unexpected_write", {22'b0, d_addr}, 32'hFFFF_FFFF);
         end else begin
            wr_t e;
            e = d_q.pop_front();
            check("d_wr_addr", {22'b0, d_addr}, {22'b0, e.addr});
            check("d_wr_data", d_data, e.data);
         end
      end
      if (o_we) begin
         if (o_q.size() == 0) begin
            check("o_unexpected_write", {30'b0, o_addr}, 32'hFFFF_FFFF);
         end else begin
            wr_t e;
            e = o_q.pop_front();
            check("o_wr_addr", {30'b0, o_addr}, {22'b0, e.addr});
            check("o_wr_data", o_data, e.data);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      #2 reset = 1'b0;
      @(posedge clk); #1;
      check("rst_we",    {31'b0, d_we},   32'd0);
      check("rst_addr",  {22'b0, d_addr}, 32'd0);
      check("rst_data",  d_data,          32'd0);
      check("rst_count", {21'b0, d_cnt},  32'd0);
      check("rst_done",  {31'b0, d_done}, 32'd0);
      check("rst_pe",    {31'b0, d_pe},   32'd0);
      check("rst_err",   {31'b0, d_err},  32'd0);
      reset = 1'b1;
      @(posedge clk); #1;

      // Basic load, DONE ignores go, restart collision, reload, back-to-back
      add(1, 0, 32'h2001_0005, 1, 0, 1, 0);
      add(1, 0, 32'h2002_0003, 1, 1, 2, 0);
      add(1, 0, HALT,          1, 2, 3, 0);
`ifdef RX_LOADER_CHECKSUM_EN
      add(1, 0, 32'h4003_0007, 0, 0, 3, 0);
`endif
      add(0, 0, 32'h0,         0, 0, 3, 1);
      add(1, 0, 32'h1234_5678, 0, 0, 3, 1);
      add(1, 1, 32'hAAAA_0000, 0, 0, 0, 0);
      add(1, 0, 32'hAAAA_0001, 1, 0, 1, 0);
      add(1, 0, HALT,          1, 1, 2, 0);
`ifdef RX_LOADER_CHECKSUM_EN
      add(1, 0, 32'hAAAA_0000, 0, 0, 2, 0);
`endif
      add(0, 0, 32'h0,         0, 0, 2, 1);
      add(0, 1, 32'h0,         0, 0, 0, 0);
      add(1, 0, 32'h0000_0011, 1, 0, 1, 0);
      add(1, 0, 32'h0000_0022, 1, 1, 2, 0);
      add(1, 0, 32'h0000_0033, 1, 2, 3, 0);
      add(1, 0, HALT,          1, 3, 4, 0);
`ifdef RX_LOADER_CHECKSUM_EN
      add(1, 0, 32'h0000_0065, 0, 0, 4, 0);
`endif
      add(0, 0, 32'h0,         0, 0, 4, 1);

      foreach (vecs[i]) begin
         if (vecs[i].exp_wr) push_d(vecs[i].exp_addr, vecs[i].din);
         cyc(vecs[i].go, vecs[i].din, vecs[i].rst);
         check($sformatf("vec%0d_count", i), {21'b0, d_cnt},  {21'b0, vecs[i].exp_cnt});
         check($sformatf("vec%0d_done",  i), {31'b0, d_done}, {31'b0, vecs[i].exp_done});
         check($sformatf("vec%0d_pe",    i), {31'b0, d_pe},   {31'b0, vecs[i].exp_done});
         check($sformatf("vec%0d_err",   i), {31'b0, d_err},  32'd0);
      end

      // Reset mid-load
      cyc(0, 32'h0, 1);
      push_d(0, 32'h0000_0055); cyc(1, 32'h0000_0055, 0);
      push_d(1, 32'h0000_0066); cyc(1, 32'h0000_0066, 0);
      cyc(0, 32'h0, 0);
      reset = 1'b0;
      @(posedge clk); #1;
      check("midrst_count", {21'b0, d_cnt},  32'd0);
      check("midrst_we",    {31'b0, d_we},   32'd0);
      check("midrst_addr",  {22'b0, d_addr}, 32'd0);
      check("midrst_data",  d_data,          32'd0);
      check("midrst_done",  {31'b0, d_done}, 32'd0);
      reset = 1'b1;
      push_d(0, 32'h0000_0077); cyc(1, 32'h0000_0077, 0);
      check("midrst_next_count", {21'b0, d_cnt}, 32'd1);
      cyc(0, 32'h0, 0);

`ifdef RX_LOADER_CHECKSUM_EN
      // Checksum accepted: 1 + HALT wraps to 0
      cyc(0, 32'h0, 1);
      push_d(0, 32'h1); cyc(1, 32'h1, 0);
      push_d(1, HALT);  cyc(1, HALT, 0);
      cyc(1, 32'h0, 0);
      cyc(0, 32'h0, 0);
      check("cks_ok_done", {31'b0, d_done}, 32'd1);
      check("cks_ok_err",  {31'b0, d_err},  32'd0);
      // Checksum rejected
      cyc(0, 32'h0, 1);
      push_d(0, 32'h1); cyc(1, 32'h1, 0);
      push_d(1, HALT);  cyc(1, HALT, 0);
      cyc(1, 32'h1, 0);
      cyc(0, 32'h0, 0);
      check("cks_bad_err",   {31'b0, d_err},  32'd1);
      check("cks_bad_pe",    {31'b0, d_pe},   32'd0);
      check("cks_bad_count", {21'b0, d_cnt},  32'd2);
`endif

      // Overflow on the 4-word instance
      for (int i = 1; i <= 5; i++) begin
         if (i <= 4) push_o(10'(i - 1), 32'(i));
         ocyc(1, 32'(i), 0);
      end
      check("ovf_count", {29'b0, o_cnt}, 32'd4);
      ocyc(0, 32'h0, 0);
      check("ovf_err",  {31'b0, o_err},  32'd1);
      check("ovf_pe",   {31'b0, o_pe},   32'd0);
      check("ovf_done", {31'b0, o_done}, 32'd0);
      ocyc(1, 32'h9, 0);
      check("ovf_ignore_err", {31'b0, o_err}, 32'd1);
      ocyc(0, 32'h0, 1);
      check("ovf_restart_err",   {31'b0, o_err}, 32'd0);
      check("ovf_restart_count", {29'b0, o_cnt}, 32'd0);

      // HALT in the last slot is legal
      push_o(0, 32'h10); ocyc(1, 32'h10, 0);
      push_o(1, 32'h20); ocyc(1, 32'h20, 0);
      push_o(2, 32'h30); ocyc(1, 32'h30, 0);
      push_o(3, HALT);   ocyc(1, HALT, 0);
`ifdef RX_LOADER_CHECKSUM_EN
      ocyc(1, 32'h0000_005F, 0);
`endif
      ocyc(0, 32'h0, 0);
      check("last_slot_done",  {31'b0, o_done}, 32'd1);
      check("last_slot_err",   {31'b0, o_err},  32'd0);
      check("last_slot_count", {29'b0, o_cnt},  32'd4);
      ocyc(1, 32'h99, 0);
      ocyc(0, 32'h0, 0);
      check("full_done_ignore_err",  {31'b0, o_err},  32'd0);
      check("full_done_ignore_done", {31'b0, o_done}, 32'd1);

      check("d_queue_drained", d_q.size(), 32'd0);
      check("o_queue_drained", o_q.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
